// File: rtl/fop_pkg.sv
// Shared types and defaults for the fop scheduler.
// Holds the controller state encoding and default sizing.
package fop_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        RUN,
        DONE
    } fop_sched_state_t;

    localparam int FOP_NREQ       = 4;
    localparam int FOP_LEN_W      = 8;
    localparam int FOP_RST_CYCLES = 2;

endpackage

// File: rtl/fop_rr_arb.sv
// Combinational round-robin arbiter.
// Scans upward from pointer with wrap; first set request wins.
module fop_rr_arb #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   pointer,
    output logic            valid,
    output logic [IW-1:0]   winner,
    output logic [NREQ-1:0] winner_oh
);

    logic [IW-1:0] idx;

    always_comb begin
        valid     = 1'b0;
        winner    = '0;
        winner_oh = '0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IW'((int'(pointer) + i) % NREQ);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
        if (valid) winner_oh[winner] = 1'b1;
    end

endmodule

// File: rtl/fop_sched.sv
// Shares one fop between NREQ requesters: reset sequencing,
// round-robin grant and fixed-length enable windows.
module fop_sched
    import fop_pkg::*;
#(
    parameter  int NREQ          = FOP_NREQ,
    parameter  int LEN_W         = FOP_LEN_W,
    parameter  int RST_CYCLES    = FOP_RST_CYCLES,
    parameter  int RESET_BETWEEN = 0,
    localparam int IW            = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][LEN_W-1:0] req_len,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic                       busy,
    output logic [IW-1:0]              owner,
    output logic                       fop_reset,
    output logic                       fop_enable
);

    fop_sched_state_t state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             busy_q, busy_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             fop_reset_q, fop_reset_d;
    logic             fop_enable_q, fop_enable_d;

    logic             arb_valid;
    logic [IW-1:0]    arb_idx;
    logic [NREQ-1:0]  arb_oh;

    fop_rr_arb #(
        .NREQ(NREQ)
    ) u_arb (
        .req      (req),
        .pointer  (ptr_q),
        .valid    (arb_valid),
        .winner   (arb_idx),
        .winner_oh(arb_oh)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        done_d       = '0;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        fop_reset_d  = fop_reset_q;
        fop_enable_d = fop_enable_q;
        unique case (state_q)
            INIT: begin
                if (cnt_q == LEN_W'(RST_CYCLES - 1)) begin
                    state_d     = IDLE;
                    fop_reset_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            IDLE: begin
                if (arb_valid) begin
                    state_d      = RUN;
                    gnt_d        = arb_oh;
                    owner_d      = arb_idx;
                    fop_enable_d = 1'b1;
                    // A zero length still runs one cycle, so the count never wraps
                    cnt_d = (req_len[arb_idx] == '0) ? LEN_W'(1)
                                                    : req_len[arb_idx];
                end
            end
            RUN: begin
                if (cnt_q == LEN_W'(1)) begin
                    state_d          = DONE;
                    fop_enable_d     = 1'b0;
                    gnt_d            = '0;
                    done_d[owner_q]  = 1'b1;
                    ptr_d = (owner_q == IW'(NREQ - 1)) ? '0
                                                       : owner_q + IW'(1);
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            DONE: begin
                cnt_d = '0;
                if (RESET_BETWEEN != 0) begin
                    state_d     = INIT;
                    fop_reset_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= INIT;
            gnt_q        <= '0;
            done_q       <= '0;
            busy_q       <= 1'b1;
            owner_q      <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            fop_reset_q  <= 1'b1;
            fop_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            fop_reset_q  <= fop_reset_d;
            fop_enable_q <= fop_enable_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign owner      = owner_q;
    assign fop_reset  = fop_reset_q;
    assign fop_enable = fop_enable_q;

endmodule

// File: tb/tb_fop_sched.sv
// Directed bench for fop_sched: one instance per RESET_BETWEEN
// setting, sharing clock and reset.
module tb_fop_sched;
    import fop_pkg::*;

    localparam int NREQ  = 4;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst_n;

    logic [NREQ-1:0]            req0, req1;
    logic [NREQ-1:0][LEN_W-1:0] len0, len1;
    logic [NREQ-1:0]            gnt0, gnt1, done0, done1;
    logic                       busy0, busy1;
    logic [1:0]                 owner0, owner1;
    logic                       frst0, frst1, fen0, fen1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fop_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .RST_CYCLES(2),
                .RESET_BETWEEN(0)) dut0 (
        .clk(clk), .reset(rst_n), .req(req0), .req_len(len0),
        .gnt(gnt0), .done(done0), .busy(busy0), .owner(owner0),
        .fop_reset(frst0), .fop_enable(fen0)
    );

    fop_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .RST_CYCLES(2),
                .RESET_BETWEEN(1)) dut1 (
        .clk(clk), .reset(rst_n), .req(req1), .req_len(len1),
        .gnt(gnt1), .done(done1), .busy(busy1), .owner(owner1),
        .fop_reset(frst1), .fop_enable(fen1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("inv_gnt0", 32'($onehot0(gnt0)), 1);
        chk("inv_done0", 32'($onehot0(done0)), 1);
        chk("inv_en_gnt0", 32'(!fen0 || $onehot(gnt0)), 1);
        chk("inv_rst_en0", 32'(frst0 && fen0), 0);
        chk("inv_gnt1", 32'($onehot0(gnt1)), 1);
        chk("inv_done1", 32'($onehot0(done1)), 1);
        chk("inv_en_gnt1", 32'(!fen1 || $onehot(gnt1)), 1);
        chk("inv_rst_en1", 32'(frst1 && fen1), 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant0(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt0 == '0 && n < 50);
        chk("grant_seen", 32'(gnt0 != '0), 1);
    endtask

    task automatic do_job(input string tag, input int idx, input int len,
                          input bit drop);
        int n, en;
        wait_grant0(n);
        chk({tag, "_gap"}, n, 1);
        chk({tag, "_owner"}, 32'(owner0), idx);
        chk({tag, "_gnt"}, 32'(gnt0), 1 << idx);
        if (drop) req0 = '0;
        en = 0;
        while (fen0 && en < 300) begin
            en++;
            tick();
        end
        chk({tag, "_len"}, en, len);
        chk({tag, "_done"}, 32'(done0), 1 << idx);
        chk({tag, "_gnt_off"}, 32'(gnt0), 0);
        tick();
        chk({tag, "_done_clr"}, 32'(done0), 0);
        chk({tag, "_idle"}, 32'(busy0), 0);
    endtask

    initial begin
        int n, k, en, rh, eh;
        rst_n = 1'b0;
        req0  = '0;
        req1  = '0;
        len0  = '0;
        len1  = '0;

        // power-up
        repeat (3) tick();
        chk("rst_frst", 32'(frst0), 1);
        chk("rst_en", 32'(fen0), 0);
        chk("rst_busy", 32'(busy0), 1);
        chk("rst_gnt", 32'(gnt0), 0);
        chk("rst_owner", 32'(owner0), 0);
        rst_n = 1'b1;
        tick();
        chk("init1_frst", 32'(frst0), 1);
        chk("init1_busy", 32'(busy0), 1);
        tick();
        chk("init2_frst", 32'(frst0), 0);
        chk("init2_busy", 32'(busy0), 0);
        chk("init2_gnt", 32'(gnt0), 0);
        chk("init2_frst1", 32'(frst1), 0);

        // contention from pointer 0
        len0 = {8'd3, 8'd3, 8'd3, 8'd3};
        req0 = 4'b1011;
        do_job("c0", 0, 3, 0);
        do_job("c1", 1, 3, 0);
        do_job("c2", 3, 3, 0);
        do_job("c3", 0, 3, 0);
        req0 = '0;

        // single job
        len0[1] = 8'd5;
        req0 = 4'b0010;
        do_job("single", 1, 5, 0);
        req0 = '0;

        // zero length clamps to one cycle
        len0[2] = 8'd0;
        req0 = 4'b0100;
        do_job("zero", 2, 1, 0);
        req0 = '0;

        // request dropped mid-job
        len0[0] = 8'd10;
        req0 = 4'b0001;
        do_job("drop", 0, 10, 1);

        // reset in the middle of a job
        len0[2] = 8'd8;
        req0 = 4'b0100;
        wait_grant0(n);
        chk("abort_owner", 32'(owner0), 2);
        tick();
        tick();
        chk("abort_pre_en", 32'(fen0), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_en", 32'(fen0), 0);
        chk("abort_gnt", 32'(gnt0), 0);
        chk("abort_frst", 32'(frst0), 1);
        chk("abort_busy", 32'(busy0), 1);
        chk("abort_owner0", 32'(owner0), 0);
        req0 = '0;
        tick();
        tick();
        chk("abort_done", 32'(done0), 0);
        rst_n = 1'b1;
        tick();
        chk("reinit1_frst", 32'(frst0), 1);
        tick();
        chk("reinit2_frst", 32'(frst0), 0);

        // pointer back at 0: requester 0 beats 3
        len0 = {8'd2, 8'd2, 8'd2, 8'd2};
        req0 = 4'b1001;
        do_job("ptr", 0, 2, 0);
        req0 = '0;

        // re-reset between jobs
        len1 = {8'd2, 8'd2, 8'd2, 8'd2};
        req1 = 4'b0011;
        k = 0;
        while (gnt1 == '0 && k < 50) begin
            tick();
            k++;
        end
        chk("rb_gnt_a", 32'(gnt1), 1);
        en = 0;
        while (fen1 && en < 50) begin
            en++;
            tick();
        end
        chk("rb_len_a", en, 2);
        chk("rb_done_a", 32'(done1), 1);
        rh = 0;
        eh = 0;
        k = 0;
        while (gnt1 == '0 && k < 50) begin
            if (frst1) rh++;
            if (fen1) eh++;
            tick();
            k++;
        end
        chk("rb_frst_cycles", rh, 2);
        chk("rb_en_between", eh, 0);
        chk("rb_gnt_b", 32'(gnt1), 2);
        chk("rb_owner_b", 32'(owner1), 1);
        chk("rb_frst_b", 32'(frst1), 0);
        req1 = '0;

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
